// File: rtl/rst_pkg.sv
// Shared encodings for the reset sequencer: reset causes, FSM states and
// the counter-width helper.
package rst_pkg;

   localparam logic [1:0] CAUSE_EXT = 2'b01;
   localparam logic [1:0] CAUSE_SW  = 2'b10;
   localparam logic [1:0] CAUSE_WDT = 2'b11;

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_HOLD = 2'd1,
      ST_REL  = 2'd2,
      ST_RUN  = 2'd3
   } state_t;

   // One spare bit above the largest value a counter must hold.
   function automatic int cnt_width(input int max_count);
      return $clog2(max_count) + 1;
   endfunction

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert flop chain for an active-low reset.
module rst_sync #(
   parameter int STAGES = 2
) (
   input  logic CLK,
   input  logic arst_n,
   output logic sync_n
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge CLK or negedge arst_n) begin
      if (!arst_n) begin
         chain <= '0;
      end else begin
         chain[0] <= 1'b1;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign sync_n = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset controller: synchronised release, hold stretch, staggered domain
// release, software/watchdog reset and last-cause recording.
module reset_sequencer
   import rst_pkg::*;
#(
   parameter int HOLD_CYCLES = 31,
   parameter int NUM_CH      = 2,
   parameter int STAGGER     = 4,
   parameter int SYNC_STAGES = 2,
   parameter int WDT_EN      = 1,
   parameter int WDT_CYCLES  = 1048576
) (
   input  logic              CLK,
   input  logic              resetn,
   input  logic              sw_rst_req,
   input  logic              wdt_kick,
   output logic [NUM_CH-1:0] rst_out,
   output logic              por_done,
   output logic [1:0]        reset_cause
);

   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
   localparam int CNT_W   = cnt_width(CNT_MAX);
   localparam int WDT_W   = cnt_width(WDT_CYCLES);
   localparam int CH_W    = cnt_width(NUM_CH);
   localparam logic [NUM_CH-1:0] ALL_ON = '1;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [NUM_CH-1:0]  rst_q, rst_d;
   logic               por_q, por_d;
   logic [1:0]         cause_q, cause_d;
   logic [WDT_W-1:0]   wdt_q, wdt_d;
   logic               sync_n;
   logic               start_rel;
   logic               hold_done, stagger_done, last_ch, wdt_at_limit, wdt_timeout;

   // The SYNC state register acts as the final synchroniser stage, so the
   // chain itself is one flop shorter than SYNC_STAGES.
   rst_sync #(.STAGES(SYNC_STAGES - 1)) u_rst_sync (
      .CLK    (CLK),
      .arst_n (resetn),
      .sync_n (sync_n)
   );

   assign hold_done    = (HOLD_CYCLES == 0) || (int'(cnt_q) == HOLD_CYCLES - 1);
   assign stagger_done = (int'(cnt_q) == STAGGER - 1);
   assign last_ch      = (int'(ch_q) == NUM_CH - 1);
   assign wdt_at_limit = (int'(wdt_q) == WDT_CYCLES - 1);
   assign wdt_timeout  = (WDT_EN != 0) && wdt_at_limit && !wdt_kick;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ch_d      = ch_q;
      rst_d     = rst_q;
      por_d     = por_q;
      cause_d   = cause_q;
      wdt_d     = wdt_q;
      start_rel = 1'b0;

      unique case (state_q)
         ST_SYNC: begin
            if (sync_n) begin
               if (HOLD_CYCLES == 0) begin
                  start_rel = 1'b1;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end
            end
         end
         ST_HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (hold_done) start_rel = 1'b1;
         end
         ST_REL: begin
            cnt_d = cnt_q + 1'b1;
            if (stagger_done) begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (int'(ch_q) == k) rst_d[k] = 1'b0;
               end
               cnt_d = '0;
               ch_d  = ch_q + 1'b1;
               if (last_ch) begin
                  state_d = ST_RUN;
                  por_d   = 1'b1;
                  wdt_d   = '0;
               end
            end
         end
         ST_RUN: begin
            if (sw_rst_req || wdt_timeout) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
               rst_d   = ALL_ON;
               por_d   = 1'b0;
               cause_d = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
            end else if (WDT_EN != 0) begin
               if (wdt_kick) wdt_d = '0;
               else if (!wdt_at_limit) wdt_d = wdt_q + 1'b1;
            end
         end
         default: state_d = ST_SYNC;
      endcase

      // Channel 0 release, shared by the SYNC and HOLD exits.
      if (start_rel) begin
         cnt_d = '0;
         ch_d  = CH_W'(1);
         if (NUM_CH == 1 || STAGGER == 0) begin
            rst_d   = '0;
            state_d = ST_RUN;
            por_d   = 1'b1;
            wdt_d   = '0;
         end else begin
            rst_d   = ALL_ON << 1;
            state_d = ST_REL;
         end
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_SYNC;
         cnt_q   <= '0;
         ch_q    <= '0;
         rst_q   <= ALL_ON;
         por_q   <= 1'b0;
         cause_q <= CAUSE_EXT;
         wdt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ch_q    <= ch_d;
         rst_q   <= rst_d;
         por_q   <= por_d;
         cause_q <= cause_d;
         wdt_q   <= wdt_d;
      end
   end

   assign rst_out     = rst_q;
   assign por_done    = por_q;
   assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations share one stimulus stream,
// a timing-formula reference model fills the expected queue every edge.
module tb_reset_sequencer;

   localparam int NDUT = 3;
   localparam int INF  = 1_000_000_000;
   localparam int P_HOLD [NDUT] = '{31, 31, 0};
   localparam int P_NCH  [NDUT] = '{2, 2, 4};
   localparam int P_STG  [NDUT] = '{4, 4, 0};
   localparam int P_SYNC [NDUT] = '{2, 2, 2};
   localparam int P_WEN  [NDUT] = '{1, 1, 0};
   localparam int P_WDT  [NDUT] = '{1048576, 16, 16};

   logic       CLK = 1'b0;
   logic       resetn, sw_rst_req, wdt_kick;
   logic [1:0] rst0, rst1;
   logic [3:0] rst2;
   logic       por0, por1, por2;
   logic [1:0] cause0, cause1, cause2;

   logic [20:0] exp_q[$];
   int          chk_cnt = 0;
   int          err_cnt = 0;
   int          edge_n  = 0;
   int          t0 [NDUT];
   int          trun [NDUT];
   int          last_clear [NDUT];
   logic [1:0]  cause_m [NDUT];
   bit          low_flag = 1'b1;

   // ---------------- clock ----------------
   always #5 CLK = ~CLK;

   reset_sequencer u_dut0 (
      .CLK(CLK), .resetn(resetn), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
      .rst_out(rst0), .por_done(por0), .reset_cause(cause0));

   reset_sequencer #(.WDT_CYCLES(16)) u_dut1 (
      .CLK(CLK), .resetn(resetn), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
      .rst_out(rst1), .por_done(por1), .reset_cause(cause1));

   reset_sequencer #(.HOLD_CYCLES(0), .NUM_CH(4), .STAGGER(0), .WDT_EN(0),
                     .WDT_CYCLES(16)) u_dut2 (
      .CLK(CLK), .resetn(resetn), .sw_rst_req(sw_rst_req), .wdt_kick(wdt_kick),
      .rst_out(rst2), .por_done(por2), .reset_cause(cause2));

   // ---------------- reference model ----------------
   // Each sequence is described by the edge t0 where channel 0 falls; channel k
   // falls at t0 + k*STAGGER and RUN begins when the last one falls.
   task automatic start_seq(input int d, input int t, input logic [1:0] c);
      t0[d]         = t;
      trun[d]       = t + (P_NCH[d] - 1) * P_STG[d];
      last_clear[d] = trun[d];
      cause_m[d]    = c;
   endtask

   function automatic logic [6:0] model_out(input int d);
      logic [3:0] r;
      r = '0;
      for (int k = 0; k < P_NCH[d]; k++) r[k] = (edge_n < t0[d] + k * P_STG[d]);
      return {r, (edge_n >= trun[d]), cause_m[d]};
   endfunction

   function automatic logic [6:0] dut_out(input int d);
      case (d)
         0:       return {2'b00, rst0, por0, cause0};
         1:       return {2'b00, rst1, por1, cause1};
         default: return {rst2, por2, cause2};
      endcase
   endfunction

   always @(negedge resetn) low_flag = 1'b1;

   always @(posedge CLK) begin : model
      logic [20:0] e;
      int hold_n;
      edge_n++;
      for (int d = 0; d < NDUT; d++) begin
         hold_n = (P_HOLD[d] == 0) ? 1 : P_HOLD[d];
         if (!resetn) begin
            t0[d] = INF; trun[d] = INF; last_clear[d] = INF; cause_m[d] = 2'b01;
         end else if (low_flag) begin
            start_seq(d, edge_n + P_SYNC[d] - 1 + P_HOLD[d], 2'b01);
         end else if (edge_n > trun[d]) begin
            if (sw_rst_req)
               start_seq(d, edge_n + hold_n, 2'b10);
            else if (P_WEN[d] != 0 && !wdt_kick && edge_n - last_clear[d] == P_WDT[d])
               start_seq(d, edge_n + hold_n, 2'b11);
            else if (wdt_kick)
               last_clear[d] = edge_n;
         end
         e[d*7 +: 7] = model_out(d);
      end
      low_flag = !resetn;
      exp_q.push_back(e);
   end

   // ---------------- scoreboard monitor ----------------
   always @(posedge CLK) begin : monitor
      logic [20:0] e;
      logic [6:0]  a, x;
      #1;
      if (exp_q.size() == 0) begin
         chk_cnt++;
         err_cnt++;
         $display("FAIL mon_queue: got empty queue at edge %0d, required one entry", edge_n);
      end else begin
         e = exp_q.pop_front();
         for (int d = 0; d < NDUT; d++) begin
            a = dut_out(d);
            x = e[d*7 +: 7];
            chk_cnt++;
            if (a !== x) begin
               err_cnt++;
               $display("FAIL mon_dut%0d edge %0d: got rst=%b por=%b cause=%b, required rst=%b por=%b cause=%b",
                        d, edge_n, a[6:3], a[2], a[1:0], x[6:3], x[2], x[1:0]);
            end
         end
      end
   end

   // ---------------- driver / directed-check tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Returns in the low clock phase just before edge number target.
   task automatic wait_before_edge(input int target);
      int guard = 0;
      while (edge_n < target - 1 && guard < 5000) begin
         @(posedge CLK); #1;
         guard++;
      end
      @(negedge CLK);
   endtask

   task automatic wait_run(input int d, input string name);
      logic [6:0] o;
      int n = 0;
      o = dut_out(d);
      while (o[2] !== 1'b1 && n < 400) begin
         @(posedge CLK); #1;
         o = dut_out(d);
         n++;
      end
      check(name, o[2], 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int e, k, k2;
      resetn = 1'b1; sw_rst_req = 1'b0; wdt_kick = 1'b0;
      #1 resetn = 1'b0;
      #1;
      check("async_reset_rst0", rst0, 2'b11);
      check("async_reset_rst2", rst2, 4'hF);
      check("async_reset_por0", por0, 1'b0);
      check("async_reset_cause0", cause0, 2'b01);
      check("async_reset_cause2", cause2, 2'b01);

      // Power-on: three low cycles, then count edges from the release.
      repeat (3) @(negedge CLK);
      resetn = 1'b1;
      for (int i = 1; i <= 53; i++) begin
         @(posedge CLK); #1;
         case (i)
            1:  check("corner_edge1_rst2", rst2, 4'hF);
            2:  begin
                   check("corner_edge2_rst2", rst2, 4'h0);
                   check("corner_edge2_por2", por2, 1'b1);
                end
            32: check("por_edge32_rst0", rst0, 2'b11);
            33: begin
                   check("por_edge33_rst0", rst0, 2'b10);
                   check("por_edge33_rst1", rst1, 2'b10);
                end
            36: begin
                   check("por_edge36_rst0", rst0, 2'b10);
                   check("por_edge36_por0", por0, 1'b0);
                end
            37: begin
                   check("por_edge37_rst0", rst0, 2'b00);
                   check("por_edge37_por0", por0, 1'b1);
                   check("por_edge37_cause0", cause0, 2'b01);
                end
            52: check("wdt_edge52_por1", por1, 1'b1);
            53: begin
                   check("wdt_edge53_rst1", rst1, 2'b11);
                   check("wdt_edge53_por1", por1, 1'b0);
                   check("wdt_edge53_cause1", cause1, 2'b11);
                end
            default: ;
         endcase
      end

      // Software reset in RUN, then requests during HOLD and REL.
      @(negedge CLK); sw_rst_req = 1'b1;
      @(posedge CLK); #1;
      e = edge_n;
      check("sw_rst0", rst0, 2'b11);
      check("sw_cause0", cause0, 2'b10);
      check("sw_por0", por0, 1'b0);
      @(negedge CLK); sw_rst_req = 1'b0;
      wait_before_edge(e + 10); sw_rst_req = 1'b1;
      @(negedge CLK); sw_rst_req = 1'b0;
      wait_before_edge(e + 30);
      @(posedge CLK); #1; check("sw_hold30_rst0", rst0, 2'b11);
      @(posedge CLK); #1; check("sw_rel31_rst0", rst0, 2'b10);
      wait_before_edge(e + 33); sw_rst_req = 1'b1;
      @(posedge CLK); #1; check("sw_in_rel_ignored", rst0, 2'b10);
      @(negedge CLK); sw_rst_req = 1'b0;
      wait_before_edge(e + 35);
      @(posedge CLK); #1;
      check("sw_rel35_rst0", rst0, 2'b00);
      check("sw_rel35_por0", por0, 1'b1);

      // Regular kicks keep the watchdog quiet.
      wait_run(1, "wait_run_dut1");
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK); wdt_kick = 1'b1;
         @(negedge CLK); wdt_kick = 1'b0;
         repeat (8) @(negedge CLK);
      end
      check("kicked_por1", por1, 1'b1);

      // Kick landing exactly on the timeout cycle, then SW + timeout together.
      @(negedge CLK); wdt_kick = 1'b1;
      @(posedge CLK); #1; k = edge_n;
      @(negedge CLK); wdt_kick = 1'b0;
      wait_before_edge(k + 16); wdt_kick = 1'b1;
      @(posedge CLK); #1; k2 = edge_n;
      check("kick_at_timeout_por1", por1, 1'b1);
      @(negedge CLK); wdt_kick = 1'b0;
      wait_before_edge(k2 + 16); sw_rst_req = 1'b1;
      @(posedge CLK); #1;
      check("sw_wdt_same_rst1", rst1, 2'b11);
      check("sw_wdt_same_cause1", cause1, 2'b10);
      @(negedge CLK); sw_rst_req = 1'b0;

      // 1 ns external reset pulse between edges while in RUN.
      wait_run(0, "wait_run_dut0");
      @(posedge CLK); #2;
      e = edge_n;
      resetn = 1'b0;
      #1;
      check("pulse_rst0", rst0, 2'b11);
      check("pulse_rst2", rst2, 4'hF);
      check("pulse_por0", por0, 1'b0);
      check("pulse_cause1", cause1, 2'b01);
      resetn = 1'b1;
      wait_before_edge(e + 32);
      @(posedge CLK); #1; check("pulse_edge32_rst0", rst0, 2'b11);
      @(posedge CLK); #1; check("pulse_edge33_rst0", rst0, 2'b10);

      // Randomised traffic, including mid-cycle reset pulses.
      for (int c = 0; c < 2500; c++) begin
         @(negedge CLK);
         sw_rst_req = ($urandom_range(0, 59) == 0);
         wdt_kick   = ($urandom_range(0, 11) == 0);
         if (resetn && $urandom_range(0, 399) == 0) resetn = 1'b0;
         else if (!resetn && $urandom_range(0, 2) == 0) resetn = 1'b1;
         if (resetn && $urandom_range(0, 499) == 0) begin
            #2 resetn = 1'b0;
            #1 resetn = 1'b1;
         end
      end
      @(negedge CLK);
      resetn = 1'b1; sw_rst_req = 1'b0; wdt_kick = 1'b0;
      repeat (5) @(negedge CLK);

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
